// File: rtl/angle_range_reducer.sv
// Folds a signed Q4.12 angle into a first-quadrant Q1.15 operand plus quadrant and cosine sign for the Taylor stage.
// Latency k+3 cycles from accept (k = pi/2 subtractions); one op in flight, result held until out_ready; ANGLE_RED_COUNT_EN adds op_count.
module angle_range_reducer #(
  parameter int unsigned HALF_PI_Q15 = 51472,
  parameter int unsigned MAX_ITER    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_angle,
  output logic [1:0]  out_quad,
  output logic        out_neg
`ifdef ANGLE_RED_COUNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam logic [19:0]   HALF_PI_ACC = 20'(HALF_PI_Q15);
  localparam logic [15:0]   HALF_PI_OUT = 16'(HALF_PI_Q15);
  localparam logic [IW-1:0] ITER_CAP    = IW'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS    = 3'd1,
    REDUCE = 3'd2,
    FOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     ang_q;
  logic [19:0]     acc;
  logic [IW-1:0]   iter;
  logic [2:0]      quad;
  logic [16:0]     mag;
  logic            sub_ok;

  // Two's-complement magnitude in 17 bits so -32768 maps to +32768 without overflow.
  assign mag    = ang_q[15] ? (17'd0 - {1'b1, ang_q}) : {1'b0, ang_q};
  assign sub_ok = (acc >= HALF_PI_ACC) && (iter < ITER_CAP);

  assign in_ready = (state == IDLE) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = ABS;
      ABS:     state_nxt = REDUCE;
      REDUCE:  if (!sub_ok) state_nxt = FOLD;
      FOLD:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ang_q     <= '0;
      acc       <= '0;
      iter      <= '0;
      quad      <= '0;
      out_valid <= 1'b0;
      out_angle <= '0;
      out_quad  <= '0;
      out_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) ang_q <= in_angle;
        end
        ABS: begin
          acc  <= {mag, 3'b000};
          iter <= '0;
          quad <= '0;
        end
        REDUCE: begin
          if (sub_ok) begin
            acc  <= acc - HALF_PI_ACC;
            quad <= quad + 3'd1;
            iter <= iter + IW'(1);
          end
        end
        FOLD: begin
          // Odd quadrants mirror the remainder about pi/2 so downstream only sees [0, pi/2].
          out_angle <= quad[0] ? (HALF_PI_OUT - acc[15:0]) : acc[15:0];
          out_quad  <= quad[1:0];
          out_neg   <= quad[0] ^ quad[1];
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ANGLE_RED_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      op_count <= '0;
    else if (out_valid && out_ready && (op_count != 16'hFFFF))
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_angle_range_reducer.sv
// Self-checking bench for angle_range_reducer: arithmetic reference model plus hand-computed directed vectors.
module tb_angle_range_reducer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_angle;
  logic [1:0]  out_quad;
  logic        out_neg;
`ifdef ANGLE_RED_COUNT_EN
  logic [15:0] op_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_ops  = 0;
  int exp_angle, exp_quad, exp_neg;

  angle_range_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_quad  (out_quad),
    .out_neg   (out_neg)
`ifdef ANGLE_RED_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input integer act, input integer exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: magnitude in Q.15, integer division by pi/2 gives the quadrant count.
  task automatic model(input logic [15:0] a, output int ang, output int q, output int neg, output int k);
    int m, r;
    m = int'($signed(a));
    if (m < 0) m = -m;
    m = m * 8;
    k = m / 51472;
    if (k > 6) k = 6;
    r = m - k * 51472;
    q = k % 4;
    ang = (q % 2 == 1) ? 51472 - r : r;
    neg = (q == 1 || q == 2) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("mon_out_angle", out_angle, exp_angle);
      check("mon_out_quad", out_quad, exp_quad);
      check("mon_out_neg", out_neg, exp_neg);
      check("mon_in_ready_busy", in_ready, 0);
    end
  end

  task automatic run_op(input logic [15:0] a, input integer lit_ang, input integer lit_q,
                        input integer lit_neg, input integer lit_lat, input int hold);
    int ea, eq, en, ek, lat, w;
    model(a, ea, eq, en, ek);
    exp_angle = ea;
    exp_quad  = eq;
    exp_neg   = en;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_op", in_ready, 1);
    in_angle = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_model", lat, ek + 3);
    if (lit_lat >= 0) begin
      check("latency_literal", lat, lit_lat);
      check("out_angle_literal", out_angle, lit_ang);
      check("out_quad_literal", out_quad, lit_q);
      check("out_neg_literal", out_neg, lit_neg);
    end
    repeat (hold) begin
      in_valid = 1'b1;
      in_angle = 16'h1000;
      @(posedge clk); #1;
      check("held_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_ops++;
    check("out_valid_cleared", out_valid, 0);
    check("in_ready_after_op", in_ready, 1);
`ifdef ANGLE_RED_COUNT_EN
    check("op_count", op_count, n_ops);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, na;
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_angle", out_angle, 0);
    check("rst_out_quad", out_quad, 0);
    check("rst_out_neg", out_neg, 0);
    check("rst_in_ready", in_ready, 0);
`ifdef ANGLE_RED_COUNT_EN
    check("rst_op_count", op_count, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);

    run_op(16'h0000, 0,     0, 0, 3, 0);
    run_op(16'h1000, 32768, 0, 0, 3, 0);
    run_op(16'h2000, 37408, 1, 1, 4, 0);
    run_op(16'hE000, 37408, 1, 1, 4, 0);
    run_op(16'h4000, 28128, 2, 1, 5, 0);
    run_op(16'h8000, 46688, 1, 1, 8, 0);
    run_op(16'h1922, 51472, 1, 1, 4, 0);
    run_op(16'h1921, 51464, 0, 0, 3, 0);
    run_op(16'h5000, 42048, 3, 0, 6, 0);
    run_op(16'h7FFF, 46696, 1, 1, 8, 0);
    run_op(16'hC000, 28128, 2, 1, 5, 10);

    // Reset while the 4.0 rad operation sits in REDUCE must abort it silently.
    exp_angle = -1;
    in_angle  = 16'h4000;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    n_ops = 0;
    @(posedge clk); #1;
    check("midrst_in_ready_release", in_ready, 1);
    w = 0;
    while (!out_valid && w < 12) begin
      @(posedge clk); #1;
      w++;
    end
    check("midrst_no_output", out_valid, 0);
`ifdef ANGLE_RED_COUNT_EN
    check("midrst_op_count", op_count, 0);
`endif

    run_op(16'h2000, 37408, 1, 1, 4, 0);
    for (int i = 0; i < 6; i++) begin
      a  = 16'($urandom);
      na = 16'd0 - a;
      run_op(a, -1, -1, -1, -1, i % 3);
      run_op(na, -1, -1, -1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
